// File: rtl/alu_issue_stage.sv
// ID/EX issue register for the MIPS150 datapath.
// Decodes the instruction into ALU operands and an ALUop, with stall/flush.
module alu_issue_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic             stall,
  input  logic             flush,
  output logic             in_ready,
  output logic             ex_valid,
  output logic [31:0]      ex_A,
  output logic [31:0]      ex_B,
  output logic [3:0]       ex_ALUop,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_LUI  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_NOR  = 4'd11;
  localparam logic [3:0] ALU_XXX  = 4'd15;

  logic [5:0]  opc, fn;
  logic [31:0] se, ze;
  logic [31:0] a_d, b_d;
  logic [3:0]  op_d;
  logic        ill_d;

  logic             valid_q, ill_q;
  logic [31:0]      a_q, b_q;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt_q;

  assign opc = instr[31:26];
  assign fn  = instr[5:0];
  assign se  = {{16{instr[15]}}, instr[15:0]};
  assign ze  = {16'b0, instr[15:0]};

  always_comb begin
    a_d   = rs_val;
    b_d   = rt_val;
    op_d  = ALU_XXX;
    ill_d = 1'b0;
    case (opc)
      6'h00: begin
        case (fn)
          6'h21: op_d = ALU_ADDU;
          6'h23: op_d = ALU_SUBU;
          6'h24: op_d = ALU_AND;
          6'h25: op_d = ALU_OR;
          6'h26: op_d = ALU_XOR;
          6'h27: op_d = ALU_NOR;
          6'h2A: op_d = ALU_SLT;
          6'h2B: op_d = ALU_SLTU;
          6'h04: op_d = ALU_SLL;
          6'h06: op_d = ALU_SRL;
          6'h07: op_d = ALU_SRA;
          6'h00: op_d = ALU_SLL;
          6'h02: op_d = ALU_SRL;
          6'h03: op_d = ALU_SRA;
          default: ill_d = 1'b1;
        endcase
        // constant shifts take the amount from the shamt field
        if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)
          a_d = {27'b0, instr[10:6]};
      end
      6'h09: begin b_d = se; op_d = ALU_ADDU; end
      6'h0A: begin b_d = se; op_d = ALU_SLT;  end
      6'h0B: begin b_d = se; op_d = ALU_SLTU; end
      6'h0C: begin b_d = ze; op_d = ALU_AND;  end
      6'h0D: begin b_d = ze; op_d = ALU_OR;   end
      6'h0E: begin b_d = ze; op_d = ALU_XOR;  end
      6'h0F: begin b_d = ze; op_d = ALU_LUI;  end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
      6'h28, 6'h29, 6'h2B: begin
        b_d  = se;
        op_d = ALU_ADDU;
      end
      default: ill_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ALU_ADDU;
      cnt_q   <= '0;
    end else if (flush || (!stall && !in_valid)) begin
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ALU_ADDU;
    end else if (!stall) begin
      valid_q <= 1'b1;
      ill_q   <= ill_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign in_ready   = !stall;
  assign ex_valid   = valid_q;
  assign ex_A       = a_q;
  assign ex_B       = b_q;
  assign ex_ALUop   = op_q;
  assign ex_illegal = ill_q;
  assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed steps then random traffic
// against a table-driven reference model; a 4-bit counter copy checks wrap.
module tb_alu_issue_stage;

  localparam logic [3:0] ADDU = 4'd0, SUBU = 4'd1, SLT = 4'd2;
  localparam logic [3:0] SLTU = 4'd3, AND_ = 4'd4, OR_ = 4'd5;
  localparam logic [3:0] XOR_ = 4'd6, LUI = 4'd7, SLL = 4'd8;
  localparam logic [3:0] SRA = 4'd9, SRL = 4'd10, NOR_ = 4'd11;
  localparam logic [3:0] XXX = 4'd15;

  logic clk = 0;
  logic rst, in_valid, stall, flush;
  logic [31:0] instr, rs_val, rt_val;
  logic in_ready, ex_valid, ex_illegal;
  logic [31:0] ex_A, ex_B;
  logic [3:0] ex_ALUop;
  logic [31:0] issued_cnt;
  logic in_ready4, ex_valid4, ex_illegal4;
  logic [31:0] ex_A4, ex_B4;
  logic [3:0] ex_ALUop4;
  logic [3:0] issued_cnt4;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] rtab [64];
  logic [3:0] itab [64];
  logic       izext [64];

  logic        m_valid, m_ill;
  logic [31:0] m_A, m_B;
  logic [3:0]  m_op;
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt4;

  always #5 clk = ~clk;

  alu_issue_stage #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
    .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .flush(flush),
    .in_ready(in_ready), .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B),
    .ex_ALUop(ex_ALUop), .ex_illegal(ex_illegal), .issued_cnt(issued_cnt)
  );

  alu_issue_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
    .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .flush(flush),
    .in_ready(in_ready4), .ex_valid(ex_valid4), .ex_A(ex_A4), .ex_B(ex_B4),
    .ex_ALUop(ex_ALUop4), .ex_illegal(ex_illegal4), .issued_cnt(issued_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [5:0] opc, fn;
    if (rst) begin
      {m_valid, m_ill, m_A, m_B, m_op, m_cnt, m_cnt4} = '0;
    end else if (flush || (!stall && !in_valid)) begin
      {m_valid, m_ill, m_A, m_B, m_op} = '0;
    end else if (!stall) begin
      opc = instr[31:26];
      fn  = instr[5:0];
      m_valid = 1;
      m_A = rs_val;
      m_B = rt_val;
      if (opc == 0) begin
        m_op = rtab[fn];
        if (fn inside {6'h00, 6'h02, 6'h03}) m_A = 32'(instr[10:6]);
      end else begin
        m_op = itab[opc];
        if (m_op != XXX)
          m_B = izext[opc] ? 32'(instr[15:0])
                           : 32'($signed(instr[15:0]));
      end
      m_ill = (m_op == XXX);
      m_cnt = m_cnt + 1;
      m_cnt4 = m_cnt4 + 4'd1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, ".A"}, ex_A, m_A);
    chk({tag, ".B"}, ex_B, m_B);
    chk({tag, ".op"}, 32'(ex_ALUop), 32'(m_op));
    chk({tag, ".ill"}, 32'(ex_illegal), 32'(m_ill));
    chk({tag, ".cnt"}, issued_cnt, m_cnt);
    chk({tag, ".cnt4"}, 32'(issued_cnt4), 32'(m_cnt4));
    chk({tag, ".rdy"}, 32'(in_ready), 32'(!stall));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] i,
                       input logic [31:0] rs, input logic [31:0] rt);
    in_valid = v;
    instr = i;
    rs_val = rs;
    rt_val = rt;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [20] = '{6'h00, 6'h00, 6'h00, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
      6'h28, 6'h29, 6'h2B, 6'h04, 6'h02};
    logic [5:0] fns [16] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07, 6'h00, 6'h02, 6'h03, 6'h08, 6'h3F};
    logic [31:0] w;
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 19)];
    if (w[31:26] == 0) w[5:0] = fns[$urandom_range(0, 15)];
    return w;
  endfunction

  initial begin
    for (int k = 0; k < 64; k++) begin
      rtab[k] = XXX;
      itab[k] = XXX;
      izext[k] = 0;
    end
    rtab[6'h21] = ADDU; rtab[6'h23] = SUBU; rtab[6'h24] = AND_;
    rtab[6'h25] = OR_;  rtab[6'h26] = XOR_; rtab[6'h27] = NOR_;
    rtab[6'h2A] = SLT;  rtab[6'h2B] = SLTU; rtab[6'h04] = SLL;
    rtab[6'h06] = SRL;  rtab[6'h07] = SRA;  rtab[6'h00] = SLL;
    rtab[6'h02] = SRL;  rtab[6'h03] = SRA;
    itab[6'h09] = ADDU; itab[6'h0A] = SLT; itab[6'h0B] = SLTU;
    itab[6'h0C] = AND_; itab[6'h0D] = OR_; itab[6'h0E] = XOR_;
    itab[6'h0F] = LUI;
    izext[6'h0C] = 1; izext[6'h0D] = 1; izext[6'h0E] = 1; izext[6'h0F] = 1;
    foreach (itab[k])
      if (k inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B})
        itab[k] = ADDU;

    rst = 1; stall = 0; flush = 0;
    drive(1, 32'h2441FFFC, 32'd99, 32'd98);
    step("rst0");
    step("rst1");
    chk("rst.op_zero", 32'(ex_ALUop), 32'd0);
    chk("rst.cnt_zero", issued_cnt, 32'd0);
    rst = 0;

    drive(1, 32'h2441FFFC, 32'd10, 32'd3);
    step("addiu");
    chk("addiu.B", ex_B, 32'hFFFFFFFC);
    chk("addiu.cnt", issued_cnt, 32'd1);

    drive(1, 32'h3441FFFC, 32'd10, 32'd3);
    step("ori");
    chk("ori.B", ex_B, 32'h0000FFFC);
    chk("ori.op", 32'(ex_ALUop), 32'(OR_));

    drive(1, 32'h00021940, 32'd77, 32'd7);
    step("sll");
    chk("sll.A", ex_A, 32'd5);
    chk("sll.op", 32'(ex_ALUop), 32'(SLL));

    drive(1, 32'h00221821, 32'h11, 32'h22);
    step("addu");
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      drive(1, $urandom, $urandom, $urandom);
      step("stall");
    end
    chk("stall.A_held", ex_A, 32'h11);
    flush = 1;
    step("flush_stall");
    chk("flush.valid", 32'(ex_valid), 32'd0);
    chk("flush.cnt", issued_cnt, 32'd4);
    stall = 0; flush = 0;

    drive(1, 32'h10220003, 32'd1, 32'd2);
    step("beq");
    chk("beq.ill", 32'(ex_illegal), 32'd1);
    chk("beq.op", 32'(ex_ALUop), 32'(XXX));

    rst = 1;
    step("rst2");
    rst = 0;
    for (int k = 0; k < 17; k++) begin
      drive(1, rand_instr(), $urandom, $urandom);
      step("wrap_v");
      if (k % 5 == 2) begin
        drive(0, rand_instr(), $urandom, $urandom);
        step("wrap_bub");
      end
    end
    chk("wrap.cnt4", 32'(issued_cnt4), 32'd1);
    chk("wrap.cnt32", issued_cnt, 32'd17);

    for (int k = 0; k < 400; k++) begin
      rst   = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 4) != 0, rand_instr(), $urandom, $urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
